// File: rtl/fifo_read_ctrl_if.sv
// fifo_read_ctrl_if
// Groups every non-clock signal of the FIFO read-side controller into one bundle.
//   wptr       : write pointer (Gray) arriving from the write domain
//   rdata      : combinational memory read data, mem[raddr]
//   raddr      : memory read address
//   rptr       : registered read pointer (Gray) returned to the write domain
//   rempty     : memory holds no unread word
//   rcount     : words in memory not yet popped (pessimistic)
//   dout       : output-stage data word
//   dout_valid : dout holds a valid word
//   dout_ready : consumer accepts dout this cycle
// The master modport is taken by the controller; the slave modport by the
// memory/consumer side.
interface fifo_read_ctrl_if #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
);
  logic [ADDR_SIZE:0]   wptr;
  logic [DATA_SIZE-1:0] rdata;
  logic [ADDR_SIZE-1:0] raddr;
  logic [ADDR_SIZE:0]   rptr;
  logic                 rempty;
  logic [ADDR_SIZE:0]   rcount;
  logic [DATA_SIZE-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;

  modport master (
    input  wptr, rdata, dout_ready,
    output raddr, rptr, rempty, rcount, dout, dout_valid
  );

  modport slave (
    output wptr, rdata, dout_ready,
    input  raddr, rptr, rempty, rcount, dout, dout_valid
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
// Read-side controller of the asynchronous FIFO, running only in the read
// clock domain. It synchronises the write Gray pointer, drives the memory read
// address, returns the read Gray pointer, flags empty, and presents data via a
// one-entry registered output stage (first-word-fall-through).
// Ports:
//   rclk    : read clock
//   rrst    : synchronous active-high reset
//   fifoBus : fifo_read_ctrl_if master modport (wptr, rdata, dout_ready in;
//             raddr, rptr, rempty, rcount, dout, dout_valid out)
module fifo_read_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  fifo_read_ctrl_if.master    fifoBus
);

  logic [ADDR_SIZE:0]   r_rq1;
  logic [ADDR_SIZE:0]   r_rq2;
  logic [ADDR_SIZE:0]   r_rbin;
  logic [ADDR_SIZE:0]   r_rptr;
  logic                 r_rempty;
  logic [DATA_SIZE-1:0] r_dout;
  logic                 r_doutValid;

  logic                 w_pop;
  logic [ADDR_SIZE:0]   w_rbinNext;
  logic [ADDR_SIZE:0]   w_rgrayNext;
  logic [ADDR_SIZE:0]   w_rq2Bin;

  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A word leaves memory only when one exists and the output stage is free or
  // being emptied this cycle, so a pop and a consume can overlap without a bubble.
  assign w_pop       = !r_rempty && (!r_doutValid || fifoBus.dout_ready);
  assign w_rbinNext  = r_rbin + {{ADDR_SIZE{1'b0}}, w_pop};
  assign w_rgrayNext = (w_rbinNext >> 1) ^ w_rbinNext;
  assign w_rq2Bin    = gray2bin(r_rq2);

  // Two-flop synchroniser for the write pointer; nothing else looks at wptr.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_rq1 <= fifoBus.wptr;
      r_rq2 <= r_rq1;
    end
  end

  // Read pointers and empty flag. Empty compares the post-pop Gray pointer so
  // the flag rises on the same edge that pops the last word.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbinNext;
      r_rptr   <= w_rgrayNext;
      r_rempty <= (w_rgrayNext == r_rq2);
    end
  end

  // One-entry output stage: load on pop, otherwise drop the word once consumed.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_dout      <= '0;
      r_doutValid <= 1'b0;
    end else if (w_pop) begin
      r_dout      <= fifoBus.rdata;
      r_doutValid <= 1'b1;
    end else if (r_doutValid && fifoBus.dout_ready) begin
      r_doutValid <= 1'b0;
    end
  end

  assign fifoBus.raddr      = r_rbin[ADDR_SIZE-1:0];
  assign fifoBus.rptr       = r_rptr;
  assign fifoBus.rempty     = r_rempty;
  // Modular difference; excludes the word sitting in the output stage.
  assign fifoBus.rcount     = w_rq2Bin - r_rbin;
  assign fifoBus.dout       = r_dout;
  assign fifoBus.dout_valid = r_doutValid;

endmodule
